// File: rtl/button_pkg.sv
// Shared constants and state encoding for the button event path.
// Defaults assume a 100 MHz system clock, matching the debouncer.
package button_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DOWN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int LONG_CYCLES_DEF   = 100_000_000;
  localparam int REPEAT_CYCLES_DEF = 20_000_000;
  localparam int CNT_W_DEF         = 27;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    DOWN = ST_DOWN,
    HOLD = ST_HOLD
  } btn_state_t;

endpackage

// File: rtl/button_edge_detect.sv
// Registers the debounced level once and derives single-cycle rise/fall strobes.
module button_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  output logic rise,
  output logic fall
);

  logic clean_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clean_q <= 1'b0;
    else        clean_q <= clean;
  end

  assign rise = clean & ~clean_q;
  assign fall = ~clean & clean_q;

endmodule

// File: rtl/button_event.sv
// Turns the debounced button level into press/release/long-press pulses and a held level.
// Auto-repeat in long hold is compiled in only when BUTTON_AUTOREPEAT_EN is defined.
module button_event
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 || CNT_W < 2) begin : g_bad_params
    $error("button_event: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             rise;
  logic             fall;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  button_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .clean (clean),
    .rise  (rise),
    .fall  (fall)
  );

  // Fall is tested before any threshold so a release can never coincide with long/repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            press <= 1'b1;
            held  <= 1'b1;
            cnt   <= '0;
            state <= DOWN;
          end
        end
        DOWN: begin
          if (fall) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            cnt        <= '0;
            state      <= HOLD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (fall) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (cnt == REPEAT_LAST) begin
            repeat_pulse <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
`endif
        end
        default: begin
          held  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef BUTTON_AUTOREPEAT_EN
  // Frozen HOLD counter: the repeat threshold is never consulted in this build.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_LAST;
  assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Randomized self-checking bench for button_event against a cycle-age reference model.
module tb_button_event;

  localparam int LONG   = 8;
  localparam int REPEAT = 4;
  localparam int CW     = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic clean;
  logic press, release_pulse, long_press, repeat_pulse, held;

  int test_count = 0;
  int fail_count = 0;

  // Reference model state: level history and cycles elapsed since the press pulse.
  bit m_prev;
  bit m_held;
  int m_age;
  bit m_press, m_rel, m_long, m_rep;

  always #5 clk = ~clk;

  button_event #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REPEAT),
    .CNT_W         (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clean         (clean),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    test_count++;
    if (got != exp) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic modelReset();
    m_prev  = 1'b0;
    m_held  = 1'b0;
    m_age   = 0;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    m_rep   = 1'b0;
  endtask

  // One clock edge of the spec's event rules, expressed as elapsed hold time.
  task automatic modelStep(input bit c);
    bit rise_m, fall_m;
    rise_m  = c && !m_prev;
    fall_m  = !c && m_prev;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    m_rep   = 1'b0;
    if (!m_held) begin
      if (rise_m) begin
        m_press = 1'b1;
        m_held  = 1'b1;
        m_age   = 0;
      end
    end else if (fall_m) begin
      m_rel  = 1'b1;
      m_held = 1'b0;
    end else begin
      m_age++;
      if (m_age == LONG) m_long = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
      if (m_age > LONG && ((m_age - LONG) % REPEAT) == 0) m_rep = 1'b1;
`endif
    end
    m_prev = c;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".press"},   int'(press),         int'(m_press));
    checkOutput({tag, ".release"}, int'(release_pulse), int'(m_rel));
    checkOutput({tag, ".long"},    int'(long_press),    int'(m_long));
    checkOutput({tag, ".repeat"},  int'(repeat_pulse),  int'(m_rep));
    checkOutput({tag, ".held"},    int'(held),          int'(m_held));
    checkOutput({tag, ".onehot"},
                int'($countones({press, release_pulse, long_press, repeat_pulse}) <= 1), 1);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".outs"},
                int'({press, release_pulse, long_press, repeat_pulse, held}), 0);
  endtask

  // Called just after an active edge (or before the first one): drive, clock, compare.
  task automatic applyStimulus(input bit c, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      clean = c;
      @(posedge clk);
      modelStep(c);
      #1;
      checkAll(tag);
    end
  endtask

  task automatic tap(input int hi, input int lo, input string tag);
    applyStimulus(1'b1, hi, tag);
    applyStimulus(1'b0, lo, tag);
  endtask

  initial begin
    int lens[8] = '{1, 2, 3, 7, 8, 9, 10, 20};
    int hi, lo;

    rst_n = 1'b0;
    clean = 1'b0;
    modelReset();
    #1;
    checkZero("reset_during");
    repeat (2) @(posedge clk);
    #1;
    checkZero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2, "after_reset");

    tap(3, 3, "short_tap");
    tap(1, 1, "b2b_a");
    tap(1, 1, "b2b_b");
    tap(2, 1, "b2b_c");
    tap(LONG, 3, "boundary_fall");
    tap(LONG + 1, 3, "just_long");
    tap(20, 3, "long_hold");

    // Asynchronous reset while the button is held, then still held after release.
    applyStimulus(1'b1, 12, "pre_reset_hold");
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("reset_async");
    modelReset();
    @(posedge clk);
    #1;
    checkZero("reset_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3, "press_after_reset");
    applyStimulus(1'b0, 3, "release_after_reset");

    for (int k = 0; k < 40; k++) begin
      hi = ($urandom_range(0, 1) == 0) ? lens[$urandom_range(0, 7)] : int'($urandom_range(1, 30));
      lo = int'($urandom_range(1, 4));
      tap(hi, lo, "random");
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/button_event.md
# button_event

Converts the debounced button level from the debouncer into single-cycle event pulses (press, release, long-press, optional auto-repeat) plus a held level. It sits directly downstream of the debouncer, one instance per button, and feeds the project's control logic, which must never act on raw levels. All outputs are registered and synchronous to `clk`.

## Interface
- `LONG_CYCLES`, default 100_000_000: hold time in clk cycles before `long_press` fires (1 s at 100 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, default 20_000_000: auto-repeat period in clk cycles; must be ≥ 2.
- `CNT_W`, default 27: hold counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).
- `clk` input 1: system clock. This is the only clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clean` input 1: debounced button level, 1 = pressed, synchronous to `clk`.
- `press` output 1: one-cycle pulse on press.
- `release` output 1: one-cycle pulse on release.
- `long_press` output 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse` output 1: one-cycle pulse every `REPEAT_CYCLES` while in long hold. Active only with the macro enabled.
- `held` output 1: level, 1 from the `press` cycle until the `release` cycle.

## Operation
- `clean_q` holds `clean` delayed by one register. Rise = `clean & ~clean_q`; fall = `~clean & clean_q`.
- FSM states: IDLE, DOWN, HOLD.
- IDLE:
  - On rise: pulse `press`, set `held`, clear `cnt`, go to DOWN.
- DOWN:
  - On fall: pulse `release`, clear `held` and `cnt`, go to IDLE.
  - Otherwise, when `cnt == LONG_CYCLES-1`: pulse `long_press`, clear `cnt`, go to HOLD.
  - Otherwise: `cnt` increments by 1.
- HOLD:
  - On fall: pulse `release`, clear `held` and `cnt`, go to IDLE.
  - With the macro enabled: when `cnt == REPEAT_CYCLES-1`, pulse `repeat_pulse` and clear `cnt`; otherwise increment `cnt`.
  - With the macro disabled: `cnt` holds its value.
- Fall and the threshold in the same cycle: fall wins. `release` fires; `long_press` and `repeat_pulse` do not.
- At most one of `press`, `release`, `long_press`, `repeat_pulse` is high in any cycle.
- `cnt` never wraps. It is bounded by the threshold compares.

## Timing
- Reset values: state IDLE, `clean_q` 0, `cnt` 0. All outputs (`press`, `release`, `long_press`, `repeat_pulse`, `held`) are 0.
- Reset asserted mid-hold: all outputs drop immediately (asynchronously). No `release` pulse is generated.
- Button held through reset deassertion: `press` fires at the first clock edge after deassertion.
- Latency:
  - `clean` rises before edge N: `press` and `held` are high after edge N (one cycle).
  - `release` has the same one-cycle latency from the fall.
- `long_press` is high exactly `LONG_CYCLES` cycles after `press` went high.
- Repeat timing: the first `repeat_pulse` comes `REPEAT_CYCLES` cycles after `long_press`, then every `REPEAT_CYCLES` cycles.
- A press/release pair needs no minimum spacing, but the debouncer already limits the edge rate.

## Configuration
- `BUTTON_AUTOREPEAT_EN` defined: the HOLD repeat counter and `repeat_pulse` logic are compiled in.
- `BUTTON_AUTOREPEAT_EN` undefined: `repeat_pulse` is tied to 0, the HOLD counter is frozen, and all other behaviour is unchanged.

## Structure
- Shared package `button_pkg`:
  - State encoding localparams `ST_IDLE=2'd0`, `ST_DOWN=2'd1`, `ST_HOLD=2'd2`.
  - Default `LONG_CYCLES`, `REPEAT_CYCLES` and `CNT_W` constants, shared with the debouncer's clock assumptions.
- One sub-module, `button_edge_detect`: holds the `clean_q` register and produces the `rise`/`fall` strobes. It is reset by `rst_n`.
- The FSM, counter and output registers live in `button_event`.

## Test plan
All scenarios use `LONG_CYCLES=8` and `REPEAT_CYCLES=4`.
- Short tap: `clean` high for 3 cycles, then low. Expect `press` 1 cycle after the rise and `release` 1 cycle after the fall. `held` is high for exactly 3 cycles; `long_press` never fires.
- Long hold, macro disabled: `clean` high for 20 cycles. Expect `long_press` 8 cycles after `press`, no `repeat_pulse`, and `release` after the fall.
- Long hold, macro enabled: `clean` high for 20 cycles. Expect `repeat_pulse` 4 and 8 cycles after `long_press`, then `release`.
- Boundary: fall lands exactly in the cycle where `cnt == 7`. Expect `release` only, no `long_press`, and state returns to IDLE.
- Reset mid-hold: `rst_n` pulsed low while `held=1`. All outputs go to 0 immediately with no `release`. With `clean` still 1, `press` fires at the first edge after deassertion.
- Reset values: check every output is 0 during and right after reset with `clean=0`. Back-to-back taps separated by 1 low cycle each produce a distinct `press`/`release` pair.
